// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared constants, FSM state type and helpers for the
// BCD-to-binary converter (bcd_to_bin, bcd_digit_adj, bcd_to_bin_if).
//
// Contents:
//   DIGIT_W, NUM_DIGITS, BIN_W, ITER : fixed datapath geometry
//   BCD_W, CNT_W                     : derived widths
//   state_e                          : converter FSM states
//   bcd_has_bad_digit()              : true if any packed BCD digit > 9
package bcd_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 3;
  localparam int BIN_W      = 10;
  localparam int ITER       = 10;

  localparam int BCD_W = DIGIT_W * NUM_DIGITS;
  // Iteration counter only has to reach ITER-1.
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic bcd_has_bad_digit(input logic [BCD_W-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (bcd[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(9)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// bcd_to_bin_if -- request/result bundle of the BCD-to-binary converter.
//
// Signals:
//   start                 : conversion request (sampled only while idle)
//   hundreds, tens, ones  : BCD digits, sampled together with start
//   bin_val               : binary result 0..999, held until next result
//   busy                  : converter is working (SHIFT or DONE)
//   done                  : one-cycle result-valid pulse
//   err                   : invalid-digit flag of the last result
// Modports:
//   master : request side (drives start/digits)
//   slave  : converter side (drives results)
interface bcd_to_bin_if;
  import bcd_pkg::*;

  logic               start;
  logic [DIGIT_W-1:0] hundreds;
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] ones;
  logic [BIN_W-1:0]   bin_val;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, hundreds, tens, ones,
    input  bin_val, busy, done, err
  );

  modport slave (
    input  start, hundreds, tens, ones,
    output bin_val, busy, done, err
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj -- combinational per-digit correction for reverse
// double-dabble: after a right shift, a BCD digit >= 8 has picked up a
// halved "ten" from its upper neighbour (16/2 = 8 instead of 10/2 = 5),
// so 3 is subtracted to restore a valid digit. Purely 4-bit; no borrow
// ever leaves the digit.
//
// Ports:
//   din  : shifted BCD digit
//   dout : corrected BCD digit
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din >= DIGIT_W'(8)) ? din - DIGIT_W'(3) : din;

endmodule

// File: rtl/bcd_to_bin.sv
// bcd_to_bin -- iterative 3-digit BCD to 10-bit binary converter
// (reverse double-dabble, one shift per clock).
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, wins over start
//   bus   : bcd_to_bin_if.slave (start/digits in, bin_val/busy/done/err out)
//
// Timing (edge E0 samples start in IDLE):
//   E1..E10  : ten shift/adjust iterations, last one enters DONE
//   E11      : DONE -> IDLE; bin_val, err and the done pulse all update
//              together so the result is valid exactly while done is high
//   E12      : IDLE may sample start again -> one conversion per 12 cycles
//
// Build option:
//   BCD_RANGE_CHECK_EN : when defined, a digit > 9 seen at sampling time
//                        forces that conversion's bin_val to 0 and raises
//                        err; when undefined, err is tied low and bad
//                        digits are converted unchecked.
module bcd_to_bin
  import bcd_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  bcd_to_bin_if.slave  bus
);

  localparam int SR_W = BCD_W + BIN_W;

  state_e             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   bin_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIN_W-1:0]   bin_val_q;
  logic               done_q;

  logic [SR_W-1:0]    sh;
  logic [BCD_W-1:0]   bcd_sh;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BIN_W-1:0]   bin_sh;
  logic               last_iter;

  // {bcd,bin} shifts as one register: the BCD LSB falls into the bin MSB.
  assign sh     = {bcd_q, bin_q} >> 1;
  assign bcd_sh = sh[SR_W-1:BIN_W];
  assign bin_sh = sh[BIN_W-1:0];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_sh [g*DIGIT_W +: DIGIT_W]),
      .dout (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign last_iter = (cnt_q == CNT_W'(ITER - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (last_iter) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef BCD_RANGE_CHECK_EN
  // Bad-digit verdict is captured with the digits and only published at
  // DONE, so err always describes the result currently on bin_val.
  logic err_pend_q;
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.start)
        err_pend_q <= bcd_has_bad_digit({bus.hundreds, bus.tens, bus.ones});
      if (state_q == DONE)
        err_q <= err_pend_q;
    end
  end

  assign bus.err = err_q;
`else
  logic err_pend_q;
  assign err_pend_q = 1'b0;
  assign bus.err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_val_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            bcd_q <= {bus.hundreds, bus.tens, bus.ones};
            bin_q <= '0;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_adj;
          bin_q <= bin_sh;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        DONE: begin
          done_q    <= 1'b1;
          bin_val_q <= err_pend_q ? '0 : bin_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.bin_val = bin_val_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have no parameters; widths are fixed by package constants (DIGIT_W=4, NUM_DIGITS=3, BIN_W=10, ITER=10).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, conversion request, sampled only in IDLE.
REQ-005 SHALL have port hundreds, input, 4, BCD hundreds digit, sampled with start.
REQ-006 SHALL have port tens, input, 4, BCD tens digit, sampled with start.
REQ-007 SHALL have port ones, input, 4, BCD ones digit, sampled with start.
REQ-008 SHALL have port bin_val, output, 10, binary result, 0..999.
REQ-009 SHALL have port busy, output, 1, high while in SHIFT or DONE.
REQ-010 SHALL have port done, output, 1, one-cycle result-valid pulse.
REQ-011 SHALL have port err, output, 1, invalid-digit flag (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 IDLE with start=1 at an edge SHALL load {hundreds,tens,ones} into a 12-bit BCD shift register, clear a 10-bit binary shift register and a 4-bit iteration counter, and move to SHIFT.
REQ-014 Each SHIFT edge SHALL right-shift {bcd,bin} as one 22-bit register, with the BCD LSB entering the binary MSB, then subtract 3 from every resulting BCD digit >= 8.
REQ-015 SHIFT SHALL perform exactly ITER=10 iterations, then move to DONE.
REQ-016 DONE SHALL last one cycle with done=1, and SHALL copy the binary register to bin_val on DONE entry, then return to IDLE.
REQ-017 Latency: done SHALL be high during the cycle after the 11th rising edge following the edge that sampled start, i.e. 11 cycles start-to-done; throughput is one conversion per 12 cycles.
REQ-018 start while busy=1 SHALL be ignored; no queuing.
REQ-019 start held high continuously SHALL cause back-to-back conversions, re-sampling in IDLE.
REQ-020 bin_val SHALL hold its last result until the next DONE; input changes after sampling SHALL NOT affect the result.
REQ-021 Arithmetic SHALL be unsigned; per-digit adjust is 4-bit, and no carries cross digits.

Reset
REQ-022 reset=1 at any edge SHALL force IDLE, bin_val=0, busy=0, done=0, err=0, and clear both shift registers and the counter.
REQ-023 Reset mid-conversion SHALL abort with no done pulse; bin_val SHALL read 0.
REQ-024 reset SHALL have priority over start on the same edge.

Configuration
REQ-025 Macro BCD_RANGE_CHECK_EN defined: at start-sampling, any digit > 9 SHALL set err=1, updated with bin_val at DONE, and SHALL force bin_val=0 for that conversion; err holds until the next DONE or reset.
REQ-026 Macro undefined: err SHALL be tied 0, and digits > 9 SHALL be converted without checking (result unspecified, but FSM timing unchanged).

Structure
REQ-027 Package bcd_pkg SHALL hold DIGIT_W, NUM_DIGITS, BIN_W, ITER and the FSM state typedef.
REQ-028 Sub-module bcd_digit_adj SHALL be a combinational 4-bit "subtract 3 if >= 8" unit, instantiated NUM_DIGITS times.

Verification
REQ-029 Digits 0,1,0 with start pulse -> done 11 cycles later, bin_val=10, err=0.
REQ-030 Digits 2,4,8 -> bin_val=248; then 1,3,9 -> bin_val=139; 9,9,9 -> bin_val=999; 0,0,0 -> 0.
REQ-031 Start pulse at cycle 3 of a conversion with different digits -> ignored; the single done carries the first result.
REQ-032 Reset asserted at SHIFT iteration 5 -> no done, busy=0 and bin_val=0 next cycle; a new start afterwards converts correctly.
REQ-033 start held high for 40 cycles with 2,5,5 -> done pulses every 12 cycles, each with bin_val=255.
REQ-034 With BCD_RANGE_CHECK_EN, digits 0,A,3 -> err=1, bin_val=0; next conversion 0,4,2 -> err=0, bin_val=42.
